seg_scan_ctrl: RTL and testbench



---
 rtl/seg_scan_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode 7-segment scan controller with a sequential
// double-dabble converter, leading-zero blanking, overflow saturation and alarm blink.
module seg_scan_ctrl #(
   parameter int N_DIGITS     = 4,
   parameter int BIN_W        = 14,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load,
   input  logic [BIN_W-1:0]    bin_in,
   input  logic                alarm,
   output logic                busy,
   output logic                overflow,
   output logic [3:0]          val,
   output logic [N_DIGITS-1:0] an
);

   localparam int WORK_W = (N_DIGITS + 1) * 4;
   localparam int DISP_W = N_DIGITS * 4;
   localparam int CNT_W  = $clog2(BIN_W + 1);
   localparam int PRE_W  = $clog2(REFRESH_DIV);
   localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [BIN_W-1:0]    bin_q, bin_d;
   logic [WORK_W-1:0]   work_q, work_d, adj_s;
   logic                lost_q, lost_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DISP_W-1:0]   disp_q, disp_d;
   logic                ovf_q, ovf_d;
   logic                busy_q, busy_d;

   logic [PRE_W-1:0]    presc_q, presc_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [FRM_W-1:0]    frame_q, frame_d;
   logic                blink_q, blink_d;
   logic [3:0]          val_q, val_d;
   logic [N_DIGITS-1:0] an_q, an_d;
   logic                wrap_s, frame_end_s, any_nz_s;
   logic [3:0]          nibble_s;

   // Add 3 to every BCD nibble that is 5 or more before the next shift.
   function automatic logic [WORK_W-1:0] dabble_adjust(input logic [WORK_W-1:0] w);
      logic [WORK_W-1:0] r;
      r = w;
      for (int i = 0; i < N_DIGITS + 1; i++) begin
         if (r[i*4 +: 4] >= 4'd5) begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
         end else begin
            r[i*4 +: 4] = r[i*4 +: 4];
         end
      end
      return r;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (load) begin
               state_d = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            if (cnt_q == CNT_W'(BIN_W - 1)) begin
               state_d = COMMIT;
            end else begin
               state_d = SHIFT;
            end
         end
         COMMIT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Converter datapath; lost_q catches any carry pushed out of the work register.
   always_comb begin
      bin_d  = bin_q;
      work_d = work_q;
      lost_d = lost_q;
      cnt_d  = cnt_q;
      disp_d = disp_q;
      ovf_d  = ovf_q;
      adj_s  = dabble_adjust(work_q);
      case (state_q)
         IDLE: begin
            if (load) begin
               bin_d  = bin_in;
               work_d = '0;
               lost_d = 1'b0;
               cnt_d  = '0;
            end else begin
               bin_d  = bin_q;
            end
         end
         SHIFT: begin
            work_d = {adj_s[WORK_W-2:0], bin_q[BIN_W-1]};
            lost_d = lost_q | adj_s[WORK_W-1];
            bin_d  = bin_q << 1;
            cnt_d  = cnt_q + CNT_W'(1);
         end
         COMMIT: begin
            if (lost_q || (work_q[WORK_W-1 -: 4] != 4'd0)) begin
               disp_d = {N_DIGITS{4'h9}};
               ovf_d  = 1'b1;
            end else begin
               disp_d = work_q[DISP_W-1:0];
               ovf_d  = 1'b0;
            end
         end
         default: begin
            work_d = '0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin_q  <= '0;
         work_q <= '0;
         lost_q <= 1'b0;
         cnt_q  <= '0;
         disp_q <= '0;
         ovf_q  <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         work_q <= work_d;
         lost_q <= lost_d;
         cnt_q  <= cnt_d;
         disp_q <= disp_d;
         ovf_q  <= ovf_d;
         busy_q <= busy_d;
      end
   end

   // Scan timing, blink phase and registered digit drive.
   always_comb begin
      wrap_s      = (presc_q == PRE_W'(REFRESH_DIV - 1));
      frame_end_s = wrap_s && (idx_q == IDX_W'(N_DIGITS - 1));
      presc_d     = wrap_s ? '0 : presc_q + PRE_W'(1);
      if (frame_end_s) begin
         idx_d = '0;
      end else if (wrap_s) begin
         idx_d = idx_q + IDX_W'(1);
      end else begin
         idx_d = idx_q;
      end
      frame_d = frame_q;
      blink_d = blink_q;
      if (!alarm) begin
         frame_d = '0;
         blink_d = 1'b0;
      end else if (frame_end_s) begin
         if (frame_q == FRM_W'(BLINK_FRAMES - 1)) begin
            frame_d = '0;
            blink_d = ~blink_q;
         end else begin
            frame_d = frame_q + FRM_W'(1);
         end
      end else begin
         frame_d = frame_q;
      end
      nibble_s = 4'h0;
      any_nz_s = 1'b0;
      for (int j = 0; j < N_DIGITS; j++) begin
         if (IDX_W'(j) == idx_q) begin
            nibble_s = disp_q[j*4 +: 4];
         end else begin
            nibble_s = nibble_s;
         end
         if ((IDX_W'(j) >= idx_q) && (disp_q[j*4 +: 4] != 4'h0)) begin
            any_nz_s = 1'b1;
         end else begin
            any_nz_s = any_nz_s;
         end
      end
      // Guard slot and blink-off both dark the whole bank.
      if (wrap_s || blink_d) begin
         an_d  = '1;
         val_d = 4'hF;
      end else begin
         an_d  = ~(N_DIGITS'(1) << idx_q);
         val_d = ((idx_q != '0) && !any_nz_s) ? 4'hF : nibble_s;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= '0;
         idx_q   <= '0;
         frame_q <= '0;
         blink_q <= 1'b0;
         an_q    <= '1;
         val_q   <= 4'hF;
      end else begin
         presc_q <= presc_d;
         idx_q   <= idx_d;
         frame_q <= frame_d;
         blink_q <= blink_d;
         an_q    <= an_d;
         val_q   <= val_d;
      end
   end

   assign busy     = busy_q;
   assign overflow = ovf_q;
   assign val      = val_q;
   assign an       = an_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with REFRESH_DIV=4, BLINK_FRAMES=2.
module tb_seg_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load = 1'b0;
   logic [13:0] bin_in = 14'd0;
   logic        alarm = 1'b0;
   logic        busy;
   logic        overflow;
   logic [3:0]  val;
   logic [3:0]  an;

   int vecs = 0;
   int errs = 0;

   seg_scan_ctrl #(
      .N_DIGITS(4), .BIN_W(14), .REFRESH_DIV(4), .BLINK_FRAMES(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .bin_in(bin_in), .alarm(alarm),
      .busy(busy), .overflow(overflow), .val(val), .an(an)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      rst_n = 1'b0;
      load  = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Collects the value shown on each digit during one scan (digit 3 in the top nibble).
   task automatic collect_digits(output logic [15:0] got, output bit ok);
      logic [3:0] seen;
      logic [3:0] one_v;
      seen = 4'h0;
      got  = 16'hxxxx;
      for (int c = 0; c < 64 && seen != 4'hF; c++) begin
         @(negedge clk);
         for (int d = 0; d < 4; d++) begin
            one_v = 4'b0001 << d;
            if (an === ~one_v) begin
               got[d*4 +: 4] = val;
               seen[d] = 1'b1;
            end
         end
      end
      ok = (seen == 4'hF);
   endtask

   // Issues one load pulse and counts the cycles busy stays high.
   task automatic run_convert(input logic [13:0] v, output int busy_cycles);
      @(negedge clk);
      bin_in = v;
      load   = 1'b1;
      @(negedge clk);
      load = 1'b0;
      busy_cycles = 0;
      for (int c = 0; c < 40 && busy === 1'b1; c++) begin
         busy_cycles++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      logic [3:0] exp_an, exp_val, one_v;
      int q, d;
      alarm = 1'b0;
      do_reset();
      vecs++;
      if (an !== 4'hF || val !== 4'hF || busy !== 1'b0 || overflow !== 1'b0) begin
         errs++;
         $display("FAIL reset_state: an=%b val=%h busy=%b ovf=%b want 1111 f 0 0", an, val, busy, overflow);
      end
      for (int p = 1; p <= 16; p++) begin
         @(negedge clk);
         q = (p - 1) % 4;
         d = ((p - 1) / 4) % 4;
         one_v = 4'b0001 << d;
         exp_an  = (q == 3) ? 4'hF : ~one_v;
         exp_val = (q == 3 || d != 0) ? 4'hF : 4'h0;
         vecs++;
         if (an !== exp_an || val !== exp_val) begin
            errs++;
            $display("FAIL scan_walk p=%0d: an=%b val=%h want an=%b val=%h", p, an, val, exp_an, exp_val);
         end
      end
   endtask

   task automatic test_convert();
      logic [13:0] vin [3]  = '{14'd1234, 14'd42, 14'd9999};
      logic [15:0] vexp [3] = '{16'h1234, 16'hFF42, 16'h9999};
      logic [15:0] got;
      bit ok;
      int bc;
      for (int i = 0; i < 3; i++) begin
         run_convert(vin[i], bc);
         vecs++;
         if (bc != 15) begin
            errs++;
            $display("FAIL busy_len %0d: %0d cycles want 15", vin[i], bc);
         end
         collect_digits(got, ok);
         vecs++;
         if (!ok || got !== vexp[i] || overflow !== 1'b0) begin
            errs++;
            $display("FAIL digits %0d: got %h ovf=%b complete=%0d want %h ovf=0", vin[i], got, overflow, ok, vexp[i]);
         end
      end
   endtask

   task automatic test_overflow();
      logic [15:0] got;
      bit ok;
      int bc;
      run_convert(14'd12000, bc);
      collect_digits(got, ok);
      vecs++;
      if (!ok || got !== 16'h9999 || overflow !== 1'b1) begin
         errs++;
         $display("FAIL ovf_12000: got %h ovf=%b want 9999 ovf=1", got, overflow);
      end
      run_convert(14'd7, bc);
      collect_digits(got, ok);
      vecs++;
      if (!ok || got !== 16'hFFF7 || overflow !== 1'b0) begin
         errs++;
         $display("FAIL ovf_clear_7: got %h ovf=%b want fff7 ovf=0", got, overflow);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] got;
      bit ok;
      int bc;
      @(negedge clk);
      bin_in = 14'd1234;
      load   = 1'b1;
      @(negedge clk);
      load = 1'b0;
      bc = 0;
      for (int c = 0; c < 40 && busy === 1'b1; c++) begin
         load   = (c == 2);
         bin_in = (c == 2) ? 14'd5678 : 14'd1234;
         bc++;
         @(negedge clk);
      end
      load = 1'b0;
      vecs++;
      if (bc != 15) begin
         errs++;
         $display("FAIL ignore_busy_len: %0d cycles want 15", bc);
      end
      collect_digits(got, ok);
      vecs++;
      if (!ok || got !== 16'h1234) begin
         errs++;
         $display("FAIL ignore_load: got %h want 1234", got);
      end
   endtask

   task automatic test_abort();
      logic [15:0] got;
      bit ok;
      int bc;
      run_convert(14'd12000, bc);
      vecs++;
      if (overflow !== 1'b1) begin
         errs++;
         $display("FAIL abort_setup_ovf: ovf=%b want 1", overflow);
      end
      @(negedge clk);
      bin_in = 14'd5678;
      load   = 1'b1;
      @(negedge clk);
      load = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      vecs++;
      if (busy !== 1'b0 || an !== 4'hF || val !== 4'hF || overflow !== 1'b0) begin
         errs++;
         $display("FAIL abort_async: busy=%b an=%b val=%h ovf=%b want 0 1111 f 0", busy, an, val, overflow);
      end
      @(negedge clk);
      rst_n = 1'b1;
      collect_digits(got, ok);
      vecs++;
      if (!ok || got !== 16'hFFF0 || busy !== 1'b0) begin
         errs++;
         $display("FAIL abort_cleared: got %h busy=%b want fff0 busy=0", got, busy);
      end
   endtask

   task automatic test_blink();
      logic [3:0] exp_an, exp_val, one_v;
      int q, d;
      alarm = 1'b1;
      do_reset();
      for (int p = 1; p <= 56; p++) begin
         if (p == 49) alarm = 1'b0;
         @(negedge clk);
         q = (p - 1) % 4;
         d = ((p - 1) / 4) % 4;
         one_v = 4'b0001 << d;
         if ((p > 32 && p <= 48) || q == 3) begin
            exp_an  = 4'hF;
            exp_val = 4'hF;
         end else begin
            exp_an  = ~one_v;
            exp_val = (d == 0) ? 4'h0 : 4'hF;
         end
         vecs++;
         if (an !== exp_an || val !== exp_val) begin
            errs++;
            $display("FAIL blink p=%0d: an=%b val=%h want an=%b val=%h", p, an, val, exp_an, exp_val);
         end
      end
   endtask

   initial begin
      test_reset();
      test_convert();
      test_overflow();
      test_back_to_back();
      test_abort();
      test_blink();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
